// File: rtl/ram_port_sequencer.sv
// ram_port_sequencer: burst controller for one port of a dual_rate_ram-style RAM.
// Write bursts stream words from wr_* into consecutive (wrapping) addresses.
// Read bursts fetch consecutive words through a 2-entry output buffer onto rd_*.
// Optional feature macro: RAM_SEQ_VERIFY_EN adds a post-write read-back checksum
// (VERIFY state) and the sticky verify_err output.
module ram_port_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_wre,
    output logic                  ram_chipe,
    output logic                  ram_nrst,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy
`ifdef RAM_SEQ_VERIFY_EN
    ,
    output logic                  verify_err
`endif
);

`ifdef RAM_SEQ_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, VERIFY} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN} state_t;
`endif

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    cnt_last;
    logic                    inflight_q;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   buf_mem [0:1];
    logic                    head_q;
    logic [1:0]              count_q, count_d;
    logic [2:0]              occ_next;
    logic                    drain_done;

`ifdef RAM_SEQ_VERIFY_EN
    logic [ADDR_WIDTH-1:0]   start_q;
    logic [ADDR_WIDTH-1:0]   len_q;
    logic [DATA_WIDTH-1:0]   wr_xor_q;
    logic [DATA_WIDTH-1:0]   rd_xor_q;
    logic                    vdone_q;
`endif

    assign cmd_ready  = (state_q == IDLE) && ram_nrst;
    assign busy       = (state_q != IDLE);
    assign rd_valid   = (count_q != 2'd0);
    assign rd_data    = rd_valid ? buf_mem[head_q] : '0;
    assign pop        = rd_valid && rd_ready;
    assign cnt_last   = (cnt_q == '0);
    // Occupancy the buffer will have once this cycle's in-flight word lands and the pop retires.
    assign occ_next   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign drain_done = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
`ifdef RAM_SEQ_VERIFY_EN
    assign push       = inflight_q && (state_q != VERIFY);
`else
    assign push       = inflight_q;
`endif
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop};

    // Next-state logic and the combinational RAM port drive for every state.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        issue       = 1'b0;
        wr_ready    = 1'b0;
        ram_chipe   = 1'b0;
        ram_wre     = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready    = 1'b1;
                ram_chipe   = wr_valid;
                ram_wre     = wr_valid;
                ram_addr    = addr_q;
                ram_data_in = wr_data;
                if (wr_valid) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (cnt_last) begin
`ifdef RAM_SEQ_VERIFY_EN
                        state_d = VERIFY;
                        addr_d  = start_q;
                        cnt_d   = len_q;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q - ADDR_ONE;
                    end
                end
            end
            READ: begin
                if (occ_next < 3'd2) begin
                    issue     = 1'b1;
                    ram_chipe = 1'b1;
                    ram_addr  = addr_q;
                    addr_d    = addr_q + ADDR_ONE;
                    if (cnt_last) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q - ADDR_ONE;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
`ifdef RAM_SEQ_VERIFY_EN
            VERIFY: begin
                if (!vdone_q) begin
                    issue     = 1'b1;
                    ram_chipe = 1'b1;
                    ram_addr  = addr_q;
                    addr_d    = addr_q + ADDR_ONE;
                    if (!cnt_last) begin
                        cnt_d = cnt_q - ADDR_ONE;
                    end
                end else if (inflight_q) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst counters, the one-deep in-flight flag and the RAM reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            ram_nrst   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            inflight_q <= issue;
            ram_nrst   <= 1'b1;
        end
    end

    // Two-entry output buffer; issue throttling guarantees a push never meets a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[head_q ^ count_q[0]] <= ram_data_out;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_d;
        end
    end

`ifdef RAM_SEQ_VERIFY_EN
    // Write/read-back checksums; the verify phase re-reads the burst range from its start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= '0;
            len_q      <= '0;
            wr_xor_q   <= '0;
            rd_xor_q   <= '0;
            verify_err <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                start_q  <= cmd_addr;
                len_q    <= cmd_len;
                wr_xor_q <= '0;
                rd_xor_q <= '0;
            end
            if ((state_q == WRITE) && wr_valid) begin
                wr_xor_q <= wr_xor_q ^ wr_data;
            end
            if ((state_q == VERIFY) && inflight_q) begin
                rd_xor_q <= rd_xor_q ^ ram_data_out;
                if (vdone_q && ((rd_xor_q ^ ram_data_out) != wr_xor_q)) begin
                    verify_err <= 1'b1;
                end
            end
        end
    end

    // Marks that every verify read has been issued and only the final capture remains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdone_q <= 1'b0;
        end else if (state_q != VERIFY) begin
            vdone_q <= 1'b0;
        end else if (!vdone_q && cnt_last) begin
            vdone_q <= 1'b1;
        end
    end
`endif

endmodule
